// File: rtl/stress_chain_checker_if.sv
// Bus bundle between the flip-flop stress generator / host and the chain checker.
// The master side supplies the sampled chain and the controls; the slave side
// (the checker) returns lock, fault and error status.
interface stress_chain_checker_if;
    logic        enable;
    logic        clear;
    logic [15:0] dummy_address;
    logic [15:0] dummy_data;
    logic        locked;
    logic        fault;
    logic        mismatch;
    logic [15:0] error_count;
    logic [31:0] first_syndrome;

    modport master (
        output enable, clear, dummy_address, dummy_data,
        input  locked, fault, mismatch, error_count, first_syndrome
    );

    modport slave (
        input  enable, clear, dummy_address, dummy_data,
        output locked, fault, mismatch, error_count, first_syndrome
    );
endinterface

// File: rtl/stress_chain_checker.sv
// Checks the 32-bit pseudorandom flip-flop chain against its recurrence:
// chain bit k (k >= 3) must equal the XOR of bits k-1..k-3 of the previous
// sample, and the value inferred for bit 2's hidden toggle must alternate.
// An ACQUIRE/LOCKED/FAULT machine tracks lock, counts errors once locked and
// remembers the syndrome of the first counted error.
module stress_chain_checker #(
    parameter int LOCK_COUNT  = 16,
    parameter int ERROR_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    stress_chain_checker_if.slave bus
);
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LOCKED  = 2'd1,
        FAULT   = 2'd2
    } state_t;

    state_t         state;
    logic [30:0]    prev_sample;
    logic           hist_valid;
    logic           toggle_prev;
    logic           toggle_valid;
    logic [RUN_W-1:0] run;
    logic [15:0]    err_count;
    logic [31:0]    syndrome_reg;
    logic           locked_reg;
    logic           fault_reg;
    logic           mismatch_reg;

    logic [31:0]    sample;
    logic [31:0]    syndrome;
    logic           toggle_now;
    logic           compare;
    logic           fail;
    logic [15:0]    err_inc;

    // Build the syndrome of the current sample against the stored history
    always_comb begin
        sample   = {bus.dummy_data, bus.dummy_address};
        syndrome = '0;
        for (int k = 3; k < 32; k++) begin
            syndrome[k] = sample[k] ^ prev_sample[k-1] ^ prev_sample[k-2] ^ prev_sample[k-3];
        end
        toggle_now  = sample[2] ^ prev_sample[1] ^ prev_sample[0];
        syndrome[2] = toggle_valid & ~(toggle_now ^ toggle_prev);
        compare     = bus.enable & hist_valid;
        fail        = compare & (syndrome != 32'd0);
        err_inc     = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
    end

    // History, lock/fault state machine, error counting and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= ACQUIRE;
            prev_sample  <= '0;
            hist_valid   <= 1'b0;
            toggle_prev  <= 1'b0;
            toggle_valid <= 1'b0;
            run          <= '0;
            err_count    <= '0;
            syndrome_reg <= '0;
            locked_reg   <= 1'b0;
            fault_reg    <= 1'b0;
            mismatch_reg <= 1'b0;
        end else if (bus.clear) begin
            state        <= ACQUIRE;
            hist_valid   <= 1'b0;
            toggle_valid <= 1'b0;
            run          <= '0;
            err_count    <= '0;
            syndrome_reg <= '0;
            locked_reg   <= 1'b0;
            fault_reg    <= 1'b0;
            mismatch_reg <= 1'b0;
        end else if (!bus.enable) begin
            hist_valid   <= 1'b0;
            toggle_valid <= 1'b0;
            mismatch_reg <= 1'b0;
        end else begin
            prev_sample  <= sample[30:0];
            hist_valid   <= 1'b1;
            mismatch_reg <= fail;
            if (compare) begin
                toggle_prev  <= toggle_now;
                toggle_valid <= 1'b1;
                case (state)
                    ACQUIRE: begin
                        if (fail) begin
                            run <= '0;
                        end else if (run == RUN_W'(LOCK_COUNT - 1)) begin
                            run        <= '0;
                            state      <= LOCKED;
                            locked_reg <= 1'b1;
                        end else begin
                            run <= run + RUN_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (fail) begin
                            err_count <= err_inc;
                            if (err_count == 16'd0) begin
                                syndrome_reg <= syndrome;
                            end
                            if (err_inc >= 16'(ERROR_LIMIT)) begin
                                state      <= FAULT;
                                locked_reg <= 1'b0;
                                fault_reg  <= 1'b1;
                            end
                        end
                    end
                    FAULT: begin
                        if (fail) begin
                            err_count <= err_inc;
                        end
                    end
                    default: begin
                        state <= ACQUIRE;
                    end
                endcase
            end
        end
    end

    assign bus.locked         = locked_reg;
    assign bus.fault          = fault_reg;
    assign bus.mismatch       = mismatch_reg;
    assign bus.error_count    = err_count;
    assign bus.first_syndrome = syndrome_reg;
endmodule

// File: doc/stress_chain_checker.md
STRESS_CHAIN_CHECKER -- requirements
Module: stress_chain_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 16: consecutive clean comparisons required to enter LOCKED.
REQ-002 Parameter ERROR_LIMIT, default 4: mismatches counted since the last reset or clear that force FAULT.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 resetn  input  1  reset is synchronous and active-low.
REQ-005 enable  input  1  sample qualifier; a sample is taken only when high.
REQ-006 clear  input  1  synchronous clear of fault, counters and syndrome.
REQ-007 dummy_address  input  16  chain bits [15:0] from the pseudorandom flip-flop stress generator.
REQ-008 dummy_data  input  16  chain bits [31:16] from the same generator.
REQ-009 locked  output  1  high in LOCKED state.
REQ-010 fault  output  1  high in FAULT state.
REQ-011 mismatch  output  1  registered one-cycle pulse per failing comparison.
REQ-012 error_count  output  16  mismatches counted in LOCKED or FAULT; saturates at 0xFFFF.
REQ-013 first_syndrome  output  32  syndrome of the first counted mismatch.

Function
REQ-014 Sample s = {dummy_data, dummy_address}; bit k corresponds to generator chain bit k.
REQ-015 History: register p holds the previous enabled sample; flag hv marks p valid.
REQ-016 A comparison occurs on every enabled cycle with hv=1; comparisons never occur when enable=0 or hv=0.
REQ-017 Recurrence check: for k in 3..31, expected s[k] = p[k-1] ^ p[k-2] ^ p[k-3]; syndrome bit k = s[k] ^ expected.
REQ-018 Toggle inference: each comparison yields t = s[2] ^ p[1] ^ p[0]; the previous inferred value is held with its own valid flag.
REQ-019 Toggle check: when a previous inferred value is valid, t SHALL equal its inverse; otherwise syndrome bit 2 is set. If it is not valid, bit 2 is 0.
REQ-020 Syndrome bits [1:0] SHALL always be 0; a comparison fails when the syndrome is nonzero.
REQ-021 Latency: mismatch is asserted in the cycle after the edge that takes the failing sample.
REQ-022 enable=0 SHALL clear hv and the toggle-valid flag, hold the state, counters and syndrome, and drive mismatch low; the next enabled sample only reloads p.
REQ-023 FSM states: ACQUIRE (reset state), LOCKED, FAULT.
REQ-024 ACQUIRE: a clean comparison increments the run counter; a failing one zeroes it and is not counted; run = LOCK_COUNT -> LOCKED, run zeroed.
REQ-025 LOCKED: a failing comparison increments error_count. The syndrome is captured if error_count was 0. error_count reaching ERROR_LIMIT -> FAULT.
REQ-026 LOCKED with clean comparisons or enable=0 remains LOCKED.
REQ-027 FAULT is sticky: it counts further mismatches and leaves only by clear or reset.
REQ-028 clear=1 (resetn high): state -> ACQUIRE; error_count, run, first_syndrome -> 0; hv and toggle-valid cleared; mismatch low. clear overrides a simultaneous failing comparison.
REQ-029 error_count SHALL saturate at 0xFFFF without wrap.

Reset
REQ-030 resetn low at an edge: state ACQUIRE; locked, fault, mismatch = 0; error_count = 0x0000; first_syndrome = 0x00000000; p, run, hv and toggle flags = 0.
REQ-031 resetn has priority over clear and enable; reset mid-FAULT or mid-LOCKED gives the REQ-030 state immediately.

Verification
REQ-032 Generator from its all-zero reset, enable high from its first cycle -> first comparison on sample 2; locked rises after the 16th clean comparison, at sample 17; mismatch stays 0 and error_count stays 0x0000 indefinitely.
REQ-033 LOCKED; invert dummy_data[4] (chain bit 20) for one cycle -> two mismatch pulses on consecutive cycles; error_count=2; first_syndrome=0x00100000; locked stays high.
REQ-034 LOCKED; inject 4 single-cycle flips spaced 10 cycles apart -> 8 mismatches; fault rises at the 4th mismatch; error_count=8. Then clear -> fault=0, locked=0, error_count=0; relock 17 enabled cycles later.
REQ-035 LOCKED; enable low 5 cycles, then high -> no mismatch pulses; locked stays high; the first enabled sample is not compared.
REQ-036 Constant 0x0000/0x0000 input, enable high -> bit-2 toggle failure from comparison 2 onward; never locked; error_count=0.
REQ-037 FAULT with error_count=0x0007; resetn low one cycle -> all outputs match REQ-030 on the next cycle.
